buf_port_arb: RTL
=================

// Module: buf_port_arb
// PURPOSE
//  Shares one single-port decode buffer (a/b/c/d) between two requesters: the host
//  slave-interface path (word-addressed SIF accesses) and the decode engine.
//  Sits between the slave-interface bridge and the buffer macro; one instance per buffer.
//  Round-robin arbitration, engine burst lock with bounded length, and read-data
//  return routed back to the requester that issued the read.
// PARAMETERS
//  MEM_AW     18  buffer word-address width
//  DW         32  data width
//  BURST_MAX  16  max consecutive engine grants under eng_lock while host is pending (>=1)
// PORTS
//  clk         in   1       clock
//  rstn        in   1       async active-low reset
//  host_req    in   1       host access request; held until host_ack
//  host_wen    in   1       1=write 0=read
//  host_addr   in   MEM_AW  word address
//  host_wdata  in   DW      write data
//  host_ack    out  1       request accepted this cycle (comb)
//  host_rvalid out  1       host read data valid (pulse)
//  host_rdata  out  DW      host read data
//  eng_req     in   1       engine request; valid/ready with eng_gnt
//  eng_wen     in   1       1=write 0=read
//  eng_addr    in   MEM_AW  word address
//  eng_wdata   in   DW      write data
//  eng_lock    in   1       keep grant on engine for next beat (burst)
//  eng_gnt     out  1       request accepted this cycle (comb)
//  eng_rvalid  out  1       engine read data valid (pulse)
//  eng_rdata   out  DW      engine read data
//  buf_wen     out  1       buffer write enable (registered)
//  buf_addr    out  MEM_AW  buffer address (registered)
//  buf_wdata   out  DW      buffer write data (registered)
//  buf_rdata   in   DW      buffer read data, 1 cycle after address
// BEHAVIOUR
//  - One accept per cycle max; host_ack & eng_gnt never both 1.
//  - FSM {IDLE, HOST, ENG} = owner of last accept. IDLE after reset / idle cycle.
//    Both requesting: IDLE->HOST; HOST->ENG; ENG->HOST unless eng_lock was set on the
//    previous engine beat and burst_cnt < BURST_MAX. Single requester always wins.
//    No request: ->IDLE; round-robin pointer (last_owner) survives IDLE.
//  - burst_cnt: clears on any host accept or engine beat with eng_lock=0; +1 per locked
//    engine beat; saturates at BURST_MAX. Lock ignored when host_req=0 (no count).
//  - Accept at cycle N: buf_wen/addr/wdata registered at edge N+1; for reads buf_rdata
//    valid cycle N+2, presented as *_rvalid=1 and *_rdata=buf_rdata same cycle (comb pass).
//    Read latency 2 from accept; fully pipelined, back-to-back reads allowed.
//  - Non-accept cycle: buf_wen=0, buf_addr holds last value.
//  - Read return owner tracked by 2-stage {valid,owner} shift register; read/write
//    interleave never misroutes data; *_rdata = 0 when *_rvalid=0.
//  - Reset (async, any time incl. mid-burst / read in flight): state IDLE, last_owner=ENG
//    (host wins first tie), burst_cnt=0, pipeline valids=0, buf_wen=0, buf_addr=0,
//    buf_wdata=0, rvalids=0; in-flight reads dropped.
// CONFIGURATION
//  BUF_PORT_ARB_HOST_PRIO_EN defined: host strictly wins every conflict; eng_lock and
//    burst_cnt ignored (counter still present, held 0). Undefined: round robin as above.
// STRUCTURE
//  Shared package: arbiter state enum (IDLE/HOST/ENG), owner encoding (OWN_HOST=0,
//   OWN_ENG=1), read-latency constant RD_LAT=2.
//  One sub-module: buf_rd_track (owner/valid shift pipe, depth RD_LAT).
// TESTING
//  1 Host write 0x00010 data 0xDEADBEEF alone -> host_ack same cycle, buf_wen=1 next cycle.
//  2 Host+engine reads together from IDLE after reset -> host first, engine next cycle;
//    host_rvalid at N+2, eng_rvalid at N+3 with their respective buffer words.
//  3 Engine locked burst of 20, host pending -> 16 engine beats, 1 host, then engine resumes.
//  4 Alternating R/W both sides, 100 random cycles -> scoreboard: no misrouted rdata,
//    never both grants, writes land in buffer model.
//  5 Assert rstn low with 2 reads in flight -> no rvalid after reset, buf_wen=0, next
//    tie goes to host.
//  6 With BUF_PORT_ARB_HOST_PRIO_EN: host req every cycle + engine locked -> engine
//    never granted until host_req drops.

Source files
------------

// File: rtl/buf_port_arb_pkg.sv
// Shared definitions for the decode-buffer port arbiter.
//  - arb_state_e : owner of the most recent accept (IDLE after reset or an idle cycle)
//  - owner_e     : requester identity carried with each read through the return pipe
//  - RD_LAT      : cycles from accept to read data presented to the requester
package buf_port_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOST = 2'd1,
        ST_ENG  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_HOST = 1'b0,
        OWN_ENG  = 1'b1
    } owner_e;

    localparam int RD_LAT = 2;

endpackage

// File: rtl/buf_port_arb_if.sv
// Requester-side bundle of the buffer port arbiter: host (SIF bridge) and
// decode-engine request/accept/read-return signals.
//  master : driven by the requesters (bridge + engine)
//  slave  : seen by the arbiter
interface buf_port_arb_if #(
    parameter int MEM_AW = 18,
    parameter int DW     = 32
);
    logic              host_req;
    logic              host_wen;
    logic [MEM_AW-1:0] host_addr;
    logic [DW-1:0]     host_wdata;
    logic              host_ack;
    logic              host_rvalid;
    logic [DW-1:0]     host_rdata;

    logic              eng_req;
    logic              eng_wen;
    logic [MEM_AW-1:0] eng_addr;
    logic [DW-1:0]     eng_wdata;
    logic              eng_lock;
    logic              eng_gnt;
    logic              eng_rvalid;
    logic [DW-1:0]     eng_rdata;

    modport master (
        output host_req, host_wen, host_addr, host_wdata,
        input  host_ack, host_rvalid, host_rdata,
        output eng_req, eng_wen, eng_addr, eng_wdata, eng_lock,
        input  eng_gnt, eng_rvalid, eng_rdata
    );

    modport slave (
        input  host_req, host_wen, host_addr, host_wdata,
        output host_ack, host_rvalid, host_rdata,
        input  eng_req, eng_wen, eng_addr, eng_wdata, eng_lock,
        output eng_gnt, eng_rvalid, eng_rdata
    );
endinterface

// File: rtl/buf_port_arb_rd_track.sv
// buf_rd_track: {valid, owner} shift pipe that follows each accepted read
// until its buffer data comes back DEPTH cycles later.
//  clk, rstn  : clock, async active-low reset (drops every in-flight read)
//  in_valid   : a read was accepted this cycle
//  in_owner   : requester that issued it
//  out_valid  : buffer read data on buf_rdata belongs to a tracked read
//  out_owner  : requester the data must be routed to
module buf_rd_track
    import buf_port_arb_pkg::*;
#(
    parameter int DEPTH = RD_LAT
) (
    input  logic   clk,
    input  logic   rstn,
    input  logic   in_valid,
    input  owner_e in_owner,
    output logic   out_valid,
    output owner_e out_owner
);
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] owner_q, owner_d;

    // Shift one stage per cycle; stage 0 captures the current accept.
    always_comb begin
        valid_d = {valid_q[DEPTH-2:0], in_valid};
        owner_d = {owner_q[DEPTH-2:0], in_owner};
    end

    // Pipe registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= {DEPTH{1'b0}};
            owner_q <= {DEPTH{1'b0}};
        end else begin
            valid_q <= valid_d;
            owner_q <= owner_d;
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_owner = owner_e'(owner_q[DEPTH-1]);
endmodule

// File: rtl/buf_port_arb.sv
// buf_port_arb: shares one single-port decode buffer between the host SIF path
// and the decode engine. One accept per cycle, round-robin on conflict, engine
// burst lock bounded to BURST_MAX consecutive beats while the host waits, and
// read data routed back to whoever issued the read (latency RD_LAT).
//  clk, rstn            : clock, async active-low reset
//  bus (slave)          : host_* / eng_* request, accept (comb), read return (comb)
//  buf_wen/addr/wdata   : registered buffer command (addr/wdata hold when idle)
//  buf_rdata            : buffer read data, one cycle after buf_addr
// Build option BUF_PORT_ARB_HOST_PRIO_EN: host wins every conflict; eng_lock is
// ignored and the burst counter is held at zero.
module buf_port_arb
    import buf_port_arb_pkg::*;
#(
    parameter int MEM_AW    = 18,
    parameter int DW        = 32,
    parameter int BURST_MAX = 16
) (
    input  logic              clk,
    input  logic              rstn,
    buf_port_arb_if.slave     bus,
    output logic              buf_wen,
    output logic [MEM_AW-1:0] buf_addr,
    output logic [DW-1:0]     buf_wdata,
    input  logic [DW-1:0]     buf_rdata
);
    localparam int            CW        = $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0] BURST_LIM = CW'(BURST_MAX);

    arb_state_e        state_q, state_d;
    owner_e            last_owner_q, last_owner_d;
    logic              lock_q, lock_d;
    logic [CW-1:0]     burst_cnt_q, burst_cnt_d;
    logic              eng_wins_s;

    logic              acc_valid_s, acc_wen_s;
    logic [MEM_AW-1:0] acc_addr_s;
    logic [DW-1:0]     acc_wdata_s;
    owner_e            acc_owner_s;

    logic              buf_wen_q, buf_wen_d;
    logic [MEM_AW-1:0] buf_addr_q, buf_addr_d;
    logic [DW-1:0]     buf_wdata_q, buf_wdata_d;

    logic              rd_valid_s;
    owner_e            rd_owner_s;

    // Arbiter state register: last owner survives idle cycles for round robin.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            last_owner_q <= OWN_ENG;
            lock_q       <= 1'b0;
            burst_cnt_q  <= {CW{1'b0}};
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            lock_q       <= lock_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    // Next-state: pick this cycle's owner and update burst tracking.
    always_comb begin
        state_d      = ST_IDLE;
        last_owner_d = last_owner_q;
        lock_d       = lock_q;
        burst_cnt_d  = burst_cnt_q;
        eng_wins_s   = 1'b0;
`ifndef BUF_PORT_ARB_HOST_PRIO_EN
        // Engine keeps the port on a tie only if the host went last, or the
        // previous engine beat asked for lock and the burst budget remains.
        if (last_owner_q == OWN_HOST) begin
            eng_wins_s = 1'b1;
        end else if (lock_q && (burst_cnt_q < BURST_LIM)) begin
            eng_wins_s = 1'b1;
        end else begin
            eng_wins_s = 1'b0;
        end
`endif
        if (bus.host_req && bus.eng_req) begin
            state_d = eng_wins_s ? ST_ENG : ST_HOST;
        end else if (bus.host_req) begin
            state_d = ST_HOST;
        end else if (bus.eng_req) begin
            state_d = ST_ENG;
        end else begin
            state_d = ST_IDLE;
        end

        case (state_d)
            ST_HOST: begin
                last_owner_d = OWN_HOST;
                burst_cnt_d  = {CW{1'b0}};
            end
            ST_ENG: begin
                last_owner_d = OWN_ENG;
`ifndef BUF_PORT_ARB_HOST_PRIO_EN
                lock_d = bus.eng_lock;
                // Lock only spends budget while the host is actually waiting.
                if (!bus.eng_lock) begin
                    burst_cnt_d = {CW{1'b0}};
                end else if (bus.host_req && (burst_cnt_q < BURST_LIM)) begin
                    burst_cnt_d = burst_cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    burst_cnt_d = burst_cnt_q;
                end
`endif
            end
            default: begin
                last_owner_d = last_owner_q;
            end
        endcase
    end

    // Outputs: accept strobes and the muxed command of the winner.
    always_comb begin
        bus.host_ack = (state_d == ST_HOST);
        bus.eng_gnt  = (state_d == ST_ENG);
        acc_valid_s  = 1'b0;
        acc_wen_s    = 1'b0;
        acc_addr_s   = {MEM_AW{1'b0}};
        acc_wdata_s  = {DW{1'b0}};
        acc_owner_s  = OWN_HOST;
        case (state_d)
            ST_HOST: begin
                acc_valid_s = 1'b1;
                acc_wen_s   = bus.host_wen;
                acc_addr_s  = bus.host_addr;
                acc_wdata_s = bus.host_wdata;
                acc_owner_s = OWN_HOST;
            end
            ST_ENG: begin
                acc_valid_s = 1'b1;
                acc_wen_s   = bus.eng_wen;
                acc_addr_s  = bus.eng_addr;
                acc_wdata_s = bus.eng_wdata;
                acc_owner_s = OWN_ENG;
            end
            default: begin
                acc_valid_s = 1'b0;
            end
        endcase
    end

    // Buffer command next value: address/data hold when nothing is accepted.
    always_comb begin
        buf_wen_d = acc_valid_s & acc_wen_s;
        if (acc_valid_s) begin
            buf_addr_d  = acc_addr_s;
            buf_wdata_d = acc_wdata_s;
        end else begin
            buf_addr_d  = buf_addr_q;
            buf_wdata_d = buf_wdata_q;
        end
    end

    // Buffer command registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            buf_wen_q   <= 1'b0;
            buf_addr_q  <= {MEM_AW{1'b0}};
            buf_wdata_q <= {DW{1'b0}};
        end else begin
            buf_wen_q   <= buf_wen_d;
            buf_addr_q  <= buf_addr_d;
            buf_wdata_q <= buf_wdata_d;
        end
    end

    assign buf_wen   = buf_wen_q;
    assign buf_addr  = buf_addr_q;
    assign buf_wdata = buf_wdata_q;

    buf_rd_track #(.DEPTH(RD_LAT)) u_rd_track (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (acc_valid_s & ~acc_wen_s),
        .in_owner  (acc_owner_s),
        .out_valid (rd_valid_s),
        .out_owner (rd_owner_s)
    );

    // Read return: pass buffer data through to the tracked owner, zero otherwise.
    always_comb begin
        if (rd_valid_s && (rd_owner_s == OWN_HOST)) begin
            bus.host_rvalid = 1'b1;
            bus.host_rdata  = buf_rdata;
        end else begin
            bus.host_rvalid = 1'b0;
            bus.host_rdata  = {DW{1'b0}};
        end
        if (rd_valid_s && (rd_owner_s == OWN_ENG)) begin
            bus.eng_rvalid = 1'b1;
            bus.eng_rdata  = buf_rdata;
        end else begin
            bus.eng_rvalid = 1'b0;
            bus.eng_rdata  = {DW{1'b0}};
        end
    end
endmodule
